result_serializer: RTL

Parallel-to-serial back end for the cascade compressor test harness. It captures the compressor's `WIDTH` single-bit column outputs in one cycle and shifts them out LSB-first on one pin under a valid/ready handshake. It mirrors the input-side serial-to-parallel shift registers, so a square26 compressor (31 result bits) can be exercised on-chip with one serial input pin per operand and one serial output pin.

---
 rtl/result_serializer_if.sv | 33 +++
 rtl/result_serializer.sv | 115 +++++++++++
 2 files changed

// File: rtl/result_serializer_if.sv
// Capture/serial handshake bundle for result_serializer.
// The master drives capture requests and downstream ready; the slave is the serializer itself.
interface result_serializer_if #(
    parameter int unsigned WIDTH = 31
);
    logic             start;
    logic [WIDTH-1:0] dst;
    logic             busy;
    logic             dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             dout_last;

    modport master (
        output start,
        output dst,
        output dout_ready,
        input  busy,
        input  dout,
        input  dout_valid,
        input  dout_last
    );

    modport slave (
        input  start,
        input  dst,
        input  dout_ready,
        output busy,
        output dout,
        output dout_valid,
        output dout_last
    );
endinterface

// File: rtl/result_serializer.sv
// Parallel-to-serial back end: captures WIDTH result columns and shifts them out LSB-first.
// Define RESULT_SERIALIZER_PARITY_EN to append an even-parity bit to every word.
module result_serializer #(
    parameter int unsigned WIDTH = 31
) (
    input logic                clk,
    input logic                rst,
    result_serializer_if.slave bus
);
    localparam int unsigned     CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

`ifdef RESULT_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;
`else
    typedef enum logic [0:0] {StIdle, StShift} state_e;
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             active;
    logic             xfer;
    logic             capture;
    logic             dout_c;
    logic             last_c;
`ifdef RESULT_SERIALIZER_PARITY_EN
    logic             par_q, par_d;
`endif

    assign active = (state_q != StIdle);
    assign xfer   = active & bus.dout_ready;

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        dout_c  = 1'b0;
        last_c  = 1'b0;
`ifdef RESULT_SERIALIZER_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            StIdle: begin
                capture = bus.start;
            end
            StShift: begin
                dout_c = sreg_q[0];
`ifndef RESULT_SERIALIZER_PARITY_EN
                last_c = (cnt_q == LastCnt);
`endif
                if (xfer) begin
                    sreg_d = sreg_q >> 1;
                    cnt_d  = cnt_q + CntW'(1);
                    if (cnt_q == LastCnt) begin
`ifdef RESULT_SERIALIZER_PARITY_EN
                        state_d = StParity;
`else
                        // A start in the final-bit cycle chains the next word with no gap.
                        state_d = StIdle;
                        capture = bus.start;
`endif
                    end
                end
            end
`ifdef RESULT_SERIALIZER_PARITY_EN
            StParity: begin
                dout_c = par_q;
                last_c = 1'b1;
                if (xfer) begin
                    state_d = StIdle;
                    capture = bus.start;
                end
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase

        if (capture) begin
            state_d = StShift;
            sreg_d  = bus.dst;
            cnt_d   = '0;
`ifdef RESULT_SERIALIZER_PARITY_EN
            par_d   = ^bus.dst;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            sreg_q  <= '0;
            cnt_q   <= '0;
`ifdef RESULT_SERIALIZER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
`ifdef RESULT_SERIALIZER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Outputs decode registered state only; dst never reaches dout combinationally.
    assign bus.busy       = active;
    assign bus.dout_valid = active;
    assign bus.dout       = dout_c;
    assign bus.dout_last  = last_c;
endmodule
